// File: rtl/operand_seq.sv
// rtl/operand_seq.sv - operand A/B vector sequencer with table, step, auto and LFSR sources
module operand_seq #(
  parameter int          WIDTH  = 32,
  parameter int          PERIOD = 50_000_000,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [2:0]       sel,
  input  logic             step,
  input  logic             out_ready,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [2:0]       idx,
  output logic             overrun,
  output logic [7:0]       vec_count
);

  typedef enum logic [1:0] {
    MODE_SW   = 2'b00,
    MODE_STEP = 2'b01,
    MODE_AUTO = 2'b10,
    MODE_LFSR = 2'b11
  } mode_e;

  localparam int CW = $clog2(PERIOD);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(PERIOD - 1);

  localparam logic [63:0]      P64 = 64'h12345678_12345678;
  localparam logic [63:0]      Q64 = 64'h33332222_33332222;
  localparam logic [WIDTH-1:0] M   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] F   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] P   = P64[WIDTH-1:0];
  localparam logic [WIDTH-1:0] Q   = Q64[WIDTH-1:0];

  function automatic logic [2*WIDTH-1:0] table_entry(input logic [2:0] i);
    case (i)
      3'd0:    table_entry = {{WIDTH{1'b0}}, {WIDTH{1'b0}}};
      3'd1:    table_entry = {WIDTH'(3), WIDTH'(12'h607)};
      3'd2:    table_entry = {M, M};
      3'd3:    table_entry = {~M, ~M};
      3'd4:    table_entry = {F, F};
      3'd5:    table_entry = {M, F};
      3'd6:    table_entry = {F, M};
      default: table_entry = {P, Q};
    endcase
  endfunction

  function automatic logic [15:0] rev16(input logic [15:0] v);
    for (int i = 0; i < 16; i++) begin
      rev16[i] = v[15-i];
    end
  endfunction

  mode_e             mode_q;
  logic              fresh_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              valid_q;
  logic [2:0]        idx_q;
  logic              overrun_q;
  logic [7:0]        count_q;
  logic [15:0]       lfsr_q;
  logic [CW-1:0]     cnt_q;

  mode_e             mode_cur;
  logic              xfer;
  logic              entering;
  logic              period_hit;
  logic              advance;
  logic [2:0]        idx_d;
  logic [15:0]       lfsr_d;
  logic [2*WIDTH-1:0] sw_pair;
  logic [2*WIDTH-1:0] next_pair;
  logic [2*WIDTH-1:0] zero_pair;

  assign mode_cur   = mode_e'(mode);
  assign xfer       = valid_q & out_ready;
  // fresh_q makes the first edge after reset behave exactly like a mode entry
  assign entering   = fresh_q | (mode_cur != mode_q);
  assign period_hit = (cnt_q == PERIOD_LAST);
  assign advance    = (mode_cur == MODE_STEP) ? step :
                      (mode_cur == MODE_AUTO) ? period_hit : 1'b0;
  assign idx_d      = idx_q + 3'd1;
  assign lfsr_d     = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign sw_pair    = table_entry(sel);
  assign next_pair  = table_entry(idx_d);
  assign zero_pair  = table_entry(3'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= MODE_SW;
      fresh_q   <= 1'b1;
      a_q       <= '0;
      b_q       <= '0;
      valid_q   <= 1'b0;
      idx_q     <= 3'd0;
      overrun_q <= 1'b0;
      count_q   <= 8'd0;
      lfsr_q    <= SEED;
      cnt_q     <= '0;
    end else begin
      fresh_q <= 1'b0;
      mode_q  <= mode_cur;
      if (xfer) begin
        count_q <= count_q + 8'd1;
      end
      if (entering) begin
        valid_q <= 1'b1;
        cnt_q   <= '0;
        case (mode_cur)
          MODE_SW: begin
            idx_q      <= sel;
            {a_q, b_q} <= sw_pair;
          end
          MODE_LFSR: begin
            idx_q <= 3'd0;
            a_q   <= {(WIDTH/16){lfsr_q}};
            b_q   <= {(WIDTH/16){rev16(lfsr_q)}};
          end
          default: begin
            idx_q      <= 3'd0;
            {a_q, b_q} <= zero_pair;
          end
        endcase
      end else begin
        case (mode_cur)
          MODE_SW: begin
            valid_q    <= 1'b1;
            idx_q      <= sel;
            {a_q, b_q} <= sw_pair;
          end
          MODE_LFSR: begin
            valid_q <= 1'b1;
            idx_q   <= 3'd0;
            if (xfer) begin
              lfsr_q <= lfsr_d;
              a_q    <= {(WIDTH/16){lfsr_d}};
              b_q    <= {(WIDTH/16){rev16(lfsr_d)}};
            end
          end
          default: begin
            if (mode_cur == MODE_AUTO) begin
              cnt_q <= period_hit ? '0 : cnt_q + CW'(1);
            end
            if (advance) begin
              if (!valid_q || xfer) begin
                idx_q      <= idx_d;
                {a_q, b_q} <= next_pair;
                valid_q    <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else if (xfer) begin
              valid_q <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign out_valid = valid_q;
  assign idx       = idx_q;
  assign overrun   = overrun_q;
  assign vec_count = count_q;

endmodule

// File: tb/tb_operand_seq.sv
// tb/tb_operand_seq.sv - directed-vector bench for operand_seq at WIDTH 32 and 16
module tb_operand_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [2:0]  sel;
  logic        step;
  logic        out_ready;

  logic [31:0] a32, b32;
  logic        v32, ovr32;
  logic [2:0]  idx32;
  logic [7:0]  cnt32;
  logic [15:0] a16, b16;
  logic        v16, ovr16;
  logic [2:0]  idx16;
  logic [7:0]  cnt16;

  int n_vec  = 0;
  int n_miss = 0;

  logic [2:0] exp_seq [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};

  always #5 clk = ~clk;

  operand_seq #(.WIDTH(32), .PERIOD(4), .SEED(16'hACE1)) u_dut32 (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .step(step), .out_ready(out_ready),
    .A(a32), .B(b32), .out_valid(v32), .idx(idx32), .overrun(ovr32), .vec_count(cnt32)
  );

  operand_seq #(.WIDTH(16), .PERIOD(4), .SEED(16'hACE1)) u_dut16 (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .step(step), .out_ready(out_ready),
    .A(a16), .B(b16), .out_valid(v16), .idx(idx16), .overrun(ovr16), .vec_count(cnt16)
  );

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] m);
    rst = 1'b1;
    mode = m;
    sel = 3'd0;
    step = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    mode = 2'b00;
    sel = 3'd0;
    step = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check_vec("rst_a", a32, 0);
    check_vec("rst_b", b32, 0);
    check_vec("rst_idx", idx32, 0);
    check_vec("rst_valid", v32, 0);
    check_vec("rst_ovr", ovr32, 0);
    check_vec("rst_cnt", cnt32, 0);

    // SW mode table lookups
    sel = 3'd7;
    rst = 1'b0;
    tick();
    check_vec("sw7_a", a32, 32'h12345678);
    check_vec("sw7_b", b32, 32'h33332222);
    check_vec("sw7_idx", idx32, 7);
    check_vec("sw7_valid", v32, 1);
    check_vec("sw7_a16", a16, 16'h5678);
    sel = 3'd1;
    tick();
    check_vec("sw1_a", a32, 32'h3);
    check_vec("sw1_b", b32, 32'h607);
    sel = 3'd2;
    tick();
    check_vec("sw2_a", a32, 32'h80000000);
    check_vec("sw2_b", b32, 32'h80000000);

    // STEP mode with a ready consumer: nine advances
    do_reset(2'b01);
    out_ready = 1'b1;
    tick();
    check_vec("step_entry_idx", idx16, 0);
    check_vec("step_entry_valid", v16, 1);
    for (int k = 1; k <= 9; k++) begin
      step = 1'b0;
      tick();
      step = 1'b1;
      tick();
      step = 1'b0;
      check_vec($sformatf("step_idx%0d", k), idx16, exp_seq[k-1]);
      check_vec($sformatf("step_cnt%0d", k), cnt16, k);
      if (k == 5) begin
        check_vec("step5_a16", a16, 16'h8000);
        check_vec("step5_b16", b16, 16'hFFFF);
      end
    end
    check_vec("step_ovr", ovr16, 0);

    // STEP mode with a stalled consumer: second advance is dropped
    do_reset(2'b01);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_vec("drain_valid", v32, 0);
    step = 1'b1;
    tick();
    step = 1'b0;
    check_vec("stall_idx1", idx32, 1);
    check_vec("stall_valid1", v32, 1);
    tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    check_vec("stall_ovr", ovr32, 1);
    check_vec("stall_idx_kept", idx32, 1);
    check_vec("stall_a_kept", a32, 32'h3);

    // advance with simultaneous transfer, then switch to SW, then async reset
    out_ready = 1'b1;
    step = 1'b1;
    tick();
    tick();
    step = 1'b0;
    out_ready = 1'b0;
    check_vec("mid_idx3", idx32, 3);
    mode = 2'b00;
    sel = 3'd2;
    tick();
    check_vec("mc_a", a32, 32'h80000000);
    check_vec("mc_b", b32, 32'h80000000);
    check_vec("mc_idx", idx32, 2);
    #3;
    rst = 1'b1;
    #1;
    check_vec("arst_a", a32, 0);
    check_vec("arst_valid", v32, 0);
    check_vec("arst_ovr", ovr32, 0);
    check_vec("arst_cnt", cnt32, 0);
    check_vec("arst_idx", idx32, 0);

    // AUTO mode, PERIOD=4, step held high must not matter
    do_reset(2'b10);
    out_ready = 1'b1;
    step = 1'b1;
    tick();
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_vec($sformatf("auto_idx_e%0d", k), idx32, 3'(k / 4));
    end
    step = 1'b0;

    // LFSR mode
    do_reset(2'b11);
    tick();
    check_vec("lfsr_a0", a32, 32'hACE1ACE1);
    check_vec("lfsr_b0", b32, 32'h87358735);
    check_vec("lfsr_idx", idx32, 0);
    check_vec("lfsr_valid", v32, 1);
    check_vec("lfsr_a16", a16, 16'hACE1);
    check_vec("lfsr_b16", b16, 16'h8735);
    tick();
    check_vec("lfsr_hold", a32, 32'hACE1ACE1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_vec("lfsr_a1", a32, 32'h56705670);
    check_vec("lfsr_b1", b32, 32'h0E6A0E6A);
    mode = 2'b00;
    tick();
    mode = 2'b11;
    tick();
    check_vec("lfsr_kept", a32, 32'h56705670);
    out_ready = 1'b1;
    repeat (65534) tick();
    out_ready = 1'b0;
    check_vec("lfsr_period", a32, 32'hACE1ACE1);
    check_vec("lfsr_cnt_wrap", cnt32, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/operand_seq.md
OPERAND_SEQ -- requirements
Module: operand_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand width; legal values 16, 32, 48, 64.
REQ-002 The block SHALL have parameter PERIOD, default 50_000_000, auto-step interval in clk cycles; minimum 2.
REQ-003 The block SHALL have parameter SEED, default 16'hACE1, LFSR reset value; must be non-zero.
REQ-004 clk  input  1  single clock, rising edge; the block SHALL have one clock only.
REQ-005 rst  input  1  reset; asynchronous and active-high.
REQ-006 mode  input  2  mode select: 00 SW, 01 STEP, 10 AUTO, 11 LFSR.
REQ-007 sel  input  3  table index for SW mode.
REQ-008 step  input  1  single-cycle advance pulse, already debounced.
REQ-009 out_ready  input  1  consumer accepts the vector.
REQ-010 A  output  WIDTH  operand A, registered.
REQ-011 B  output  WIDTH  operand B, registered.
REQ-012 out_valid  output  1  A/B hold a vector not yet consumed.
REQ-013 idx  output  3  table index currently on A/B.
REQ-014 overrun  output  1  sticky: an advance was dropped.
REQ-015 vec_count  output  8  accepted transfers, wraps 255->0.

Function
REQ-016 The table SHALL hold 8 pairs (A;B), where M = MSB-only, F = all-ones, and P/Q = low WIDTH bits of 64'h12345678_12345678 / 64'h33332222_33332222:
 0: 0;0  1: 3;'h607  2: M;M  3: ~M;~M  4: F;F  5: M;F  6: F;M  7: P;Q.
REQ-017 A transfer SHALL be any cycle with out_valid=1 and out_ready=1.
REQ-018 SW mode: A/B/idx SHALL load table[sel] every cycle, with 1-cycle latency; out_valid SHALL stay 1; transfers SHALL only increment vec_count.
REQ-019 STEP mode: an advance SHALL be a step pulse.
REQ-020 AUTO mode: an advance SHALL be generated internally once every PERIOD cycles by a counter that resets to 0 on mode entry; step SHALL be ignored.
REQ-021 STEP/AUTO advance: if out_valid=0, or a transfer occurs the same cycle, idx SHALL become (idx+1) mod 8 (7 wraps to 0), A/B SHALL load the new entry, and out_valid SHALL be 1 on the next edge.
REQ-022 STEP/AUTO advance while out_valid=1 and no transfer: the advance SHALL be dropped and overrun SHALL be set, with A/B unchanged.
REQ-023 STEP/AUTO transfer without advance: out_valid SHALL clear on the next edge, with A/B held.
REQ-024 LFSR mode: a 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL run.
REQ-025 LFSR mode: A SHALL be the LFSR value replicated WIDTH/16 times.
REQ-026 LFSR mode: B SHALL be the bit-reversed LFSR value replicated WIDTH/16 times.
REQ-027 LFSR mode: out_valid SHALL stay 1; each transfer SHALL advance the LFSR one step and load the new A/B on the same edge; idx SHALL hold 0.
REQ-028 The LFSR SHALL advance only in LFSR mode and SHALL keep its state across mode changes.
REQ-029 Mode change (mode differs from the previously registered mode): on the next edge, idx SHALL be 0 (SW: sel), A/B SHALL be that entry (LFSR: current LFSR value), out_valid SHALL be 1, and the period counter SHALL be 0.
REQ-030 On a mode-change cycle, a pending transfer SHALL still count, and a pending advance SHALL be discarded without setting overrun.
REQ-031 overrun SHALL clear only on reset.
REQ-032 vec_count SHALL increment on every transfer, in all modes.

Reset
REQ-033 While rst=1: A=0, B=0, idx=0, out_valid=0, overrun=0, vec_count=0, LFSR=SEED, period counter=0, and the registered mode=current mode.
REQ-034 First edge after rst falls: the block SHALL load per mode as on mode entry (REQ-029) and out_valid SHALL become 1.
REQ-035 rst asserted mid-operation SHALL force the reset values immediately, independent of clk.

Verification
REQ-036 WIDTH=32, SW mode, sel=7 -> one cycle later A=32'h12345678, B=32'h33332222, idx=7, out_valid=1.
REQ-037 WIDTH=16, STEP mode, out_ready=1, 9 step pulses -> idx sequence 1..7,0,1; entry 5 gives A=16'h8000, B=16'hFFFF; vec_count=9; overrun=0.
REQ-038 STEP mode, out_ready=0, two steps after reset -> first advance gives idx=1, out_valid=1; second is dropped: overrun=1, idx stays 1.
REQ-039 AUTO mode, PERIOD=4, out_ready=1 -> idx advances every 4 cycles; step input has no effect.
REQ-040 WIDTH=32, LFSR mode, SEED=16'hACE1 -> A=32'hACE1ACE1, B=32'h87358735; each transfer yields a new value; after 65535 transfers, A returns to 32'hACE1ACE1.
REQ-041 Mid-STEP sequence (idx=3), switch to SW with sel=2 -> A=B=32'h80000000 next cycle; assert rst asynchronously -> all outputs at reset values before the next clk edge.
